mux2_rr_arbiter: RTL and testbench

Sequencing controller for the team's 2:1 mux datapath (A/B inputs, select S, output Y). Two requesters present data with valid/ready handshakes. The block arbitrates between them with a round-robin, burst-limited policy and drives the mux select. The selected word is registered onto a single valid/ready output channel with one-cycle latency. It sits between two producers and one shared downstream consumer.

---
 rtl/mux2_rr_arbiter_pkg.sv | 33 +++
 rtl/mux2_rr_arbiter_mux2_w.sv | 13 +
 rtl/mux2_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings and helpers for the round-robin, burst-limited 2:1 mux arbiter.
package mux2_rr_arbiter_pkg;

  localparam int CNT_W = 4;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_A = 2'd1,
    ST_SERVE_B = 2'd2
  } state_e;

  // State that records ownership by the given source.
  function automatic state_e serve_state(input logic src);
    if (src == SRC_B) begin
      return ST_SERVE_B;
    end else begin
      return ST_SERVE_A;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] lim);
    if (c >= lim) begin
      return lim;
    end else begin
      return c + 4'd1;
    end
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2_w.sv
// Parameterized combinational 2:1 multiplexer; s=0 selects a, s=1 selects b.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-limited arbiter steering two valid/ready producers through a
// 2:1 mux into a single registered valid/ready output channel.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src
);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               y_valid_q, y_valid_d;
  logic [WIDTH-1:0]   y_data_q, y_data_d;
  logic               y_src_q, y_src_d;

  logic               load;
  logic               win_vld;
  logic               win_src;
  logic [WIDTH-1:0]   mux_y;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .a (a_data),
    .b (b_data),
    .s (win_src),
    .y (mux_y)
  );

  // Winner selection: a sole requester wins; under contention the owner keeps the
  // grant until its burst is used up, and from IDLE the grant goes opposite to last.
  always_comb begin
    load    = !y_valid_q || y_ready;
    win_vld = 1'b0;
    win_src = SRC_A;
    if (a_valid && b_valid) begin
      win_vld = 1'b1;
      case (state_q)
        ST_SERVE_A: win_src = (cnt_q < BURST_C) ? SRC_A : SRC_B;
        ST_SERVE_B: win_src = (cnt_q < BURST_C) ? SRC_B : SRC_A;
        default:    win_src = ~last_q;
      endcase
    end else if (a_valid) begin
      win_vld = 1'b1;
      win_src = SRC_A;
    end else if (b_valid) begin
      win_vld = 1'b1;
      win_src = SRC_B;
    end else begin
      win_vld = 1'b0;
      win_src = SRC_A;
    end
  end

  // Handshake back to the producers; held low while reset is asserted.
  always_comb begin
    a_ready = rst_n && load && win_vld && (win_src == SRC_A);
    b_ready = rst_n && load && win_vld && (win_src == SRC_B);
  end

  // Next-state for the output register, ownership state, burst counter and last winner.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_src_d   = y_src_q;
    if (load && win_vld) begin
      y_valid_d = 1'b1;
      y_data_d  = mux_y;
      y_src_d   = win_src;
      state_d   = serve_state(win_src);
      last_d    = win_src;
      if (state_q == serve_state(win_src)) begin
        cnt_d = sat_inc(cnt_q, BURST_C);
      end else begin
        cnt_d = 4'd1;
      end
    end else if (load) begin
      y_valid_d = 1'b0;
      state_d   = ST_IDLE;
      cnt_d     = 4'd0;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; last resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      last_q    <= SRC_B;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_src_q   <= SRC_A;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_src_q   <= y_src_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_src   = y_src_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (WIDTH=8, BURST=4).
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_ready;
  logic [7:0] b_data;
  logic       y_valid, y_ready;
  logic [7:0] y_data;
  logic       y_src;

  int vectors;
  int errs;

  mux2_rr_arbiter #(.WIDTH(8), .BURST(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .y_src   (y_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    a_data  = 8'h00; b_data = 8'h00;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a_data = 8'h5A; b_data = 8'hA5;
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if (y_valid !== 1'b0 || y_data !== 8'h00 || y_src !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%b, want v=0 d=00 s=0", y_valid, y_data, y_src);
    end
    vectors++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: got a_ready=%b b_ready=%b, want 0 0", a_ready, b_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    apply_reset();
    a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b0; y_ready = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errs++;
      $display("FAIL single_a_ready: got a=%b b=%b, want 1 0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    vectors++;
    if (y_valid !== 1'b1 || y_data !== 8'h11 || y_src !== 1'b0) begin
      errs++;
      $display("FAIL single_a_out: got v=%b d=%h s=%b, want v=1 d=11 s=0", y_valid, y_data, y_src);
    end
    step();
    vectors++;
    if (y_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_a_drain: got y_valid=%b, want 0", y_valid);
    end
  endtask

  task automatic test_burst();
    logic [11:0] exp_src;
    exp_src = 12'b0000_1111_0000; // bit i = expected source of transfer i
    apply_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_data = 8'hA0 + 8'(i);
      b_data = 8'hB0 + 8'(i);
      #1;
      vectors++;
      if ((a_ready ^ b_ready) !== 1'b1 || b_ready !== exp_src[i]) begin
        errs++;
        $display("FAIL burst_ready[%0d]: got a=%b b=%b, want b=%b exactly one", i, a_ready, b_ready, exp_src[i]);
      end
      step();
      vectors++;
      if (y_valid !== 1'b1 || y_src !== exp_src[i] ||
          y_data !== (exp_src[i] ? (8'hB0 + 8'(i)) : (8'hA0 + 8'(i)))) begin
        errs++;
        $display("FAIL burst_out[%0d]: got v=%b s=%b d=%h, want s=%b", i, y_valid, y_src, y_data, exp_src[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [4:0] exp_src;
    exp_src = 5'b11000;
    apply_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a_data = 8'h22; b_data = 8'h33;
    step();
    y_ready = 1'b0; a_data = 8'h44; b_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        errs++;
        $display("FAIL stall_ready[%0d]: got a=%b b=%b, want 0 0", i, a_ready, b_ready);
      end
      step();
      vectors++;
      if (y_valid !== 1'b1 || y_data !== 8'h22 || y_src !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%b, want v=1 d=22 s=0", i, y_valid, y_data, y_src);
      end
    end
    y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (y_src !== exp_src[i] || y_data !== (exp_src[i] ? 8'h55 : 8'h44)) begin
        errs++;
        $display("FAIL stall_resume[%0d]: got s=%b d=%h, want s=%b", i, y_src, y_data, exp_src[i]);
      end
    end
  endtask

  task automatic test_drop_a();
    logic [6:0] a_pat;
    logic [6:0] exp_src;
    a_pat   = 7'b1111011;
    exp_src = 7'b0111100;
    apply_reset();
    b_valid = 1'b1; y_ready = 1'b1; a_data = 8'h0A; b_data = 8'h0B;
    for (int i = 0; i < 7; i++) begin
      a_valid = a_pat[i];
      step();
      vectors++;
      if (y_valid !== 1'b1 || y_src !== exp_src[i]) begin
        errs++;
        $display("FAIL drop_a[%0d]: got v=%b s=%b, want v=1 s=%b", i, y_valid, y_src, exp_src[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1; a_data = 8'h61; b_data = 8'h62;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (y_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: got v=%b a=%b b=%b, want 0 0 0", y_valid, a_ready, b_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_ready: got a=%b b=%b, want 1 0", a_ready, b_ready);
    end
    step();
    vectors++;
    if (y_valid !== 1'b1 || y_src !== 1'b0 || y_data !== 8'h61) begin
      errs++;
      $display("FAIL post_reset_out: got v=%b s=%b d=%h, want v=1 s=0 d=61", y_valid, y_src, y_data);
    end
  endtask

  task automatic test_idle_tie();
    apply_reset();
    y_ready = 1'b1; a_data = 8'h71; b_data = 8'h72;
    for (int r = 0; r < 2; r++) begin
      // r=0: B served alone, then tie must go to A; r=1: A was last, tie goes to B
      a_valid = 1'b0; b_valid = 1'b0;
      if (r == 0) b_valid = 1'b1;
      else        a_valid = 1'b1;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      step();
      vectors++;
      if (y_valid !== 1'b0) begin
        errs++;
        $display("FAIL idle_gap[%0d]: got y_valid=%b, want 0", r, y_valid);
      end
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      vectors++;
      if (a_ready !== (r == 0) || b_ready !== (r == 1)) begin
        errs++;
        $display("FAIL idle_tie_ready[%0d]: got a=%b b=%b", r, a_ready, b_ready);
      end
      step();
      vectors++;
      if (y_valid !== 1'b1 || y_src !== (r == 1)) begin
        errs++;
        $display("FAIL idle_tie_out[%0d]: got v=%b s=%b, want s=%0d", r, y_valid, y_src, r);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    #3;
    test_reset();
    test_single_a();
    test_burst();
    test_stall();
    test_drop_a();
    test_async_reset();
    test_idle_tie();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
